// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the ID/EX pipeline register
//   DW/RW/AW : datapath, register-ID and ALU-op widths
//   REG_ZERO : ID of the hardwired-zero register
//   id_ex_ctrl_t : control bundle carried from ID into EX
package pipe_pkg;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int AW = 4;

  localparam logic [RW-1:0] REG_ZERO = 4'h0;

  typedef struct packed {
    logic [AW-1:0] aluop;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
  } id_ex_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use detection and IF/ID stall
//   in : ex_valid, ex_memread, ex_rd   (instruction currently in EX)
//        id_valid, id_rs, id_rt, id_uses_rt (instruction currently in ID)
//        mem_stall
//   out: load_use    : ID depends on a load still in EX
//        stall_if_id : hold PC and IF/ID this cycle
module hazard_detect #(
  parameter int RW = 4
) (
  input  logic          ex_valid,
  input  logic          ex_memread,
  input  logic [RW-1:0] ex_rd,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          mem_stall,
  output logic          load_use,
  output logic          stall_if_id
);
  import pipe_pkg::*;

  logic rs_match;
  logic rt_match;

  // A load into r0 never produces a value, so it can never be a hazard.
  assign rs_match = (ex_rd == id_rs);
  assign rt_match = id_uses_rt && (ex_rd == id_rt);

  assign load_use = ex_valid && ex_memread && id_valid &&
                    (ex_rd != RW'(REG_ZERO)) && (rs_match || rt_match);

  assign stall_if_id = load_use || mem_stall;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use bubble insertion
//   in : clk, rst (sync, active-high)
//        id_* : decoded instruction from ID (valid, reg IDs, operands, imm, control)
//        wb_regwrite/wb_rd/wb_data : WB-stage regfile write, bypassed into operands
//        flush : kill the instruction in ID; mem_stall : freeze the pipe
//   out: stall_if_id (comb), ex_* registered instruction for EX, bubble_cnt
module id_ex_pipe_reg #(
  parameter int DW    = 16,
  parameter int RW    = 4,
  parameter int AW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_uses_rt,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [AW-1:0]    id_aluop,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             wb_regwrite,
  input  logic [RW-1:0]    wb_rd,
  input  logic [DW-1:0]    wb_data,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             stall_if_id,
  output logic             ex_valid,
  output logic [RW-1:0]    ex_rs,
  output logic [RW-1:0]    ex_rt,
  output logic [RW-1:0]    ex_rd,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [AW-1:0]    ex_aluop,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [CNT_W-1:0] bubble_cnt
);
  import pipe_pkg::*;

  id_ex_ctrl_t id_ctrl;
  id_ex_ctrl_t ctrl_q;
  logic        load_use;
  logic        bubble;
  logic        wb_hit_rs;
  logic        wb_hit_rt;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  hazard_detect #(
    .RW (RW)
  ) u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_memread  (ctrl_q.memread),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .mem_stall   (mem_stall),
    .load_use    (load_use),
    .stall_if_id (stall_if_id)
  );

  // An invalid slot must not write anything downstream, so its whole
  // control bundle is zeroed before it is latched.
  always_comb begin
    id_ctrl = '0;
    if (id_valid) begin
      id_ctrl.aluop    = id_aluop;
      id_ctrl.regwrite = id_regwrite;
      id_ctrl.memread  = id_memread;
      id_ctrl.memwrite = id_memwrite;
    end
  end

  // WB writes the regfile in the same cycle ID reads it; the regfile read
  // returns the old value, so take the WB data directly instead.
  assign wb_hit_rs = wb_regwrite && (wb_rd != RW'(REG_ZERO)) && (wb_rd == id_rs);
  assign wb_hit_rt = wb_regwrite && (wb_rd != RW'(REG_ZERO)) && (wb_rd == id_rt);
  assign rs_fwd    = wb_hit_rs ? wb_data : id_rs_data;
  assign rt_fwd    = wb_hit_rt ? wb_data : id_rt_data;

  assign bubble = flush || load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ctrl_q     <= '0;
    end else if (!mem_stall) begin
      if (bubble) begin
        // Zero IDs plus regwrite=0 keep the bubble invisible to forwarding.
        ex_valid   <= 1'b0;
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_rd      <= '0;
        ex_rs_data <= '0;
        ex_rt_data <= '0;
        ex_imm     <= '0;
        ctrl_q     <= '0;
      end else begin
        ex_valid   <= id_valid;
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_rd      <= id_rd;
        ex_rs_data <= rs_fwd;
        ex_rt_data <= rt_fwd;
        ex_imm     <= id_imm;
        ctrl_q     <= id_ctrl;
      end
    end
  end

  // Only bubbles caused by load-use are counted; a flush in the same cycle
  // takes precedence and the cycle is attributed to the branch instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!mem_stall && !flush && load_use && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_aluop    = ctrl_q.aluop;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;

endmodule
